// File: rtl/fifo_buffer.sv
// fifo_buffer: synchronous FIFO of 2**Na words with a four-phase valid/busy
// handshake on both the write side (receiver) and the read side (sender).
module fifo_buffer #(
  parameter int Nd = 8,
  parameter int Na = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [Nd-1:0] data_in,
  input  logic          di_valid,
  output logic          full_empty,
  output logic [Nd-1:0] data_out,
  output logic          do_valid,
  input  logic          busy_ready,
  output logic [Na:0]   count,
  output logic          empty,
  output logic          full
);

  localparam int DEPTH = 1 << Na;

  typedef enum logic {
    IN_IDLE,
    IN_ACK
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_WAIT
  } out_state_t;

  in_state_t     in_state, in_next;
  out_state_t    out_state, out_next;
  logic [Nd-1:0] mem [DEPTH];
  logic [Na-1:0] wr_ptr, rd_ptr;
  logic          push, pop, load;

  // Flags decode the registered occupancy only, so they have no input path.
  assign empty = (count == '0);
  assign full  = (count == (Na+1)'(DEPTH));

  // Next-state and strobe decode for both handshake FSMs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    in_next  = in_state;
    out_next = out_state;
    push     = 1'b0;
    pop      = 1'b0;
    load     = 1'b0;

    unique case (in_state)
      IN_IDLE: if (di_valid && !full) begin
        push    = 1'b1;
        in_next = IN_ACK;
      end
      IN_ACK:  if (!di_valid) in_next = IN_IDLE;
      default: in_next = IN_IDLE;
    endcase

    unique case (out_state)
      OUT_IDLE: if (!empty && !busy_ready) begin
        load     = 1'b1;
        out_next = OUT_REQ;
      end
      // The presented word stays counted until the sink acknowledges it.
      OUT_REQ:  if (busy_ready) begin
        pop      = 1'b1;
        out_next = OUT_WAIT;
      end
      OUT_WAIT: if (!busy_ready) out_next = OUT_IDLE;
      default:  out_next = OUT_IDLE;
    endcase
  end

  // State, pointers, occupancy and registered handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      in_state   <= IN_IDLE;
      out_state  <= OUT_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_empty <= 1'b0;
      do_valid   <= 1'b0;
      data_out   <= '0;
    end else begin
      in_state   <= in_next;
      out_state  <= out_next;
      full_empty <= (in_next == IN_ACK);
      do_valid   <= (out_next == OUT_REQ);
      if (push) wr_ptr <= wr_ptr + Na'(1);
      if (pop)  rd_ptr <= rd_ptr + Na'(1);
      if (load) data_out <= mem[rd_ptr];
      unique case ({push, pop})
        2'b10:   count <= count + (Na+1)'(1);
        2'b01:   count <= count - (Na+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; stale words are unreachable
    // because count gates every read, and leaving it out keeps it a plain RAM.
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_fifo_buffer.sv
// Bench for fifo_buffer: one Na=3 instance for directed boundary tests and an
// Na=2 -> Na=1 cascade for wrap/order tests. Expected words are queued when a
// write is acknowledged and compared by monitors when the DUT presents them.
module tb_fifo_buffer;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] data_in_a, data_out_a;
  logic       di_valid_a, full_empty_a, do_valid_a, busy_a, empty_a, full_a;
  logic [3:0] count_a;

  logic [7:0] data_in_b, data_out_b, data_out_c;
  logic       di_valid_b, full_empty_b, do_valid_b, empty_b, full_b;
  logic       full_empty_c, do_valid_c, busy_c, empty_c, full_c;
  logic [2:0] count_b;
  logic [1:0] count_c;

  int checks = 0;
  int passes = 0;
  int rx_c   = 0;
  bit sink_en_a = 1'b1;
  bit sink_en_c = 1'b1;
  logic [7:0] q_a[$];
  logic [7:0] q_c[$];

  always #5 clk = ~clk;

  fifo_buffer #(.Nd(8), .Na(3)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in_a), .di_valid(di_valid_a),
    .full_empty(full_empty_a), .data_out(data_out_a), .do_valid(do_valid_a),
    .busy_ready(busy_a), .count(count_a), .empty(empty_a), .full(full_a)
  );

  fifo_buffer #(.Nd(8), .Na(2)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in_b), .di_valid(di_valid_b),
    .full_empty(full_empty_b), .data_out(data_out_b), .do_valid(do_valid_b),
    .busy_ready(full_empty_c), .count(count_b), .empty(empty_b), .full(full_b)
  );

  fifo_buffer #(.Nd(8), .Na(1)) dut_c (
    .clk(clk), .rst(rst), .data_in(data_out_b), .di_valid(do_valid_b),
    .full_empty(full_empty_c), .data_out(data_out_c), .do_valid(do_valid_c),
    .busy_ready(busy_c), .count(count_c), .empty(empty_c), .full(full_c)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Sink for instance A: ack one clock after do_valid, release after it drops.
  initial begin
    busy_a = 1'b0;
    forever begin
      @(negedge clk);
      if (do_valid_a && sink_en_a && !busy_a) begin
        if (q_a.size() == 0) begin
          checks++;
          $display("FAIL sb_a actual=%0h required=no_word", data_out_a);
        end else check("sb_a_data", data_out_a, q_a.pop_front());
        busy_a = 1'b1;
      end else if (!do_valid_a && busy_a) busy_a = 1'b0;
    end
  end

  // Sink at the end of the cascade.
  initial begin
    busy_c = 1'b0;
    forever begin
      @(negedge clk);
      if (do_valid_c && sink_en_c && !busy_c) begin
        if (q_c.size() == 0) begin
          checks++;
          $display("FAIL sb_c actual=%0h required=no_word", data_out_c);
        end else check("sb_c_data", data_out_c, q_c.pop_front());
        rx_c++;
        busy_c = 1'b1;
      end else if (!do_valid_c && busy_c) busy_c = 1'b0;
    end
  end

  task automatic release_a();
    int n = 0;
    di_valid_a = 1'b0;
    do begin @(negedge clk); n++; end while (full_empty_a && n < 50);
    if (full_empty_a) timeout("release_a");
  endtask

  task automatic put_a(input logic [7:0] d);
    int n = 0;
    data_in_a  = d;
    di_valid_a = 1'b1;
    do begin @(negedge clk); n++; end while (!full_empty_a && n < 200);
    if (!full_empty_a) timeout("put_a");
    else q_a.push_back(d);
    release_a();
  endtask

  task automatic put_b(input logic [7:0] d);
    int n = 0;
    data_in_b  = d;
    di_valid_b = 1'b1;
    do begin @(negedge clk); n++; end while (!full_empty_b && n < 200);
    if (!full_empty_b) timeout("put_b");
    else q_c.push_back(d);
    di_valid_b = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (full_empty_b && n < 50);
    if (full_empty_b) timeout("release_b");
  endtask

  task automatic wait_empty_a(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((count_a != 0 || do_valid_a || busy_a) && n < 300);
    check(name, count_a, 0);
  endtask

  task automatic set_sink_a(input bit en);
    @(posedge clk);
    #1 sink_en_a = en;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    data_in_a  = 8'h55;
    di_valid_a = 1'b1;
    data_in_b  = 8'h00;
    di_valid_b = 1'b0;

    // Reset held for two edges with a write pending.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_full_empty", full_empty_a, 0);
      check("rst_do_valid", do_valid_a, 0);
      check("rst_count", count_a, 0);
      check("rst_empty", empty_a, 1);
      check("rst_full", full_a, 0);
      check("rst_data_out", data_out_a, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("write_after_reset", full_empty_a, 1);
    q_a.push_back(8'h55);
    release_a();
    wait_empty_a("reset_word_drained");

    // Single word: ack at E, presented at E+1.
    data_in_a  = 8'h41;
    di_valid_a = 1'b1;
    @(negedge clk);
    check("single_ack", full_empty_a, 1);
    check("single_not_yet_valid", do_valid_a, 0);
    check("single_count", count_a, 1);
    q_a.push_back(8'h41);
    di_valid_a = 1'b0;
    @(negedge clk);
    check("single_fall_through", do_valid_a, 1);
    check("single_data", data_out_a, 8'h41);
    wait_empty_a("single_drained");
    check("single_empty", empty_a, 1);

    // Fill with the sink stalled, then one pending write past full.
    set_sink_a(1'b0);
    for (int i = 0; i < 8; i++) put_a(8'(i));
    check("fill_full", full_a, 1);
    check("fill_count", count_a, 8);
    data_in_a  = 8'h08;
    di_valid_a = 1'b1;
    repeat (5) @(negedge clk);
    check("full_holdoff", full_empty_a, 0);
    check("full_presenting", do_valid_a, 1);
    set_sink_a(1'b1);
    @(negedge clk);                   // sink raises busy here; pop next edge
    check("pre_pop_count", count_a, 8);
    @(negedge clk);                   // pop edge: write must still wait
    check("no_accept_on_pop", full_empty_a, 0);
    check("pop_count", count_a, 7);
    @(negedge clk);
    check("accept_after_pop", full_empty_a, 1);
    check("refill_count", count_a, 8);
    q_a.push_back(8'h08);
    release_a();
    wait_empty_a("fill_drained");

    // Push and pop on the same edge at count 3.
    set_sink_a(1'b0);
    put_a(8'h10);
    put_a(8'h11);
    put_a(8'h12);
    check("pp_count_before", count_a, 3);
    @(posedge clk);
    #1;
    data_in_a  = 8'h13;
    di_valid_a = 1'b1;
    sink_en_a  = 1'b1;
    @(negedge clk);                   // sink raises busy; both act next edge
    @(negedge clk);
    check("push_pop_same_edge", count_a, 3);
    check("pp_ack", full_empty_a, 1);
    q_a.push_back(8'h13);
    release_a();
    wait_empty_a("pp_drained");

    // Cascade: 20 words through Na=2 then Na=1 with two 12-cycle sink stalls.
    fork
      for (int i = 0; i < 20; i++) put_b(8'(i));
      begin
        repeat (20) @(posedge clk);
        #1 sink_en_c = 1'b0;
        repeat (12) @(posedge clk);
        #1 sink_en_c = 1'b1;
        repeat (25) @(posedge clk);
        #1 sink_en_c = 1'b0;
        repeat (12) @(posedge clk);
        #1 sink_en_c = 1'b1;
      end
    join
    for (int n = 0; n < 400 && rx_c < 20; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("cascade_word_count", rx_c, 20);
    check("cascade_count_b", count_b, 0);
    check("cascade_count_c", count_c, 0);
    check("cascade_empty_c", empty_c, 1);
    check("cascade_sb_left", q_c.size(), 0);
    check("a_sb_left", q_a.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
